// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the NanoQuarter pipeline.
//
// Owns the program counter, drives a synchronous instruction memory (one-cycle
// read latency) and registers the fetched 16-bit word into the IF/ID register.
// A one-entry skid buffer catches the word still in flight when a stall is
// raised, so nothing is lost or duplicated once the stall releases.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   stall_flg     hold fetch and the IF/ID register
//   jmp_flg       unconditional redirect to tgt_addr
//   brnch_flg     branch resolved this cycle; brnch_taken selects redirect
//   tgt_addr      redirect target
//   imem_addr     read address (= pc_q)
//   imem_rd       read enable; data returns on imem_data one cycle later
//   imem_data     read data from instruction memory
//   instr         IF/ID instruction register
//   instr_pc      address of instr
//   instr_vld     instr holds a real instruction (0 = nop slot)
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_flg,
    input  logic              jmp_flg,
    input  logic              brnch_flg,
    input  logic              brnch_taken,
    input  logic [ADDR_W-1:0] tgt_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_vld
);

    typedef enum logic [1:0] {
        StRun,
        StHold,
        StDrain,
        StRedir
    } mode_e;

    logic              redir;
    mode_e             mode;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_vld_q, req_vld_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [15:0]       skid_q, skid_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              skid_vld_q, skid_vld_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_vld_q, instr_vld_d;

    assign redir     = jmp_flg | (brnch_flg & brnch_taken);
    assign imem_addr = pc_q;
    assign imem_rd   = ~stall_flg & ~redir;
    assign instr     = instr_q;
    assign instr_pc  = instr_pc_q;
    assign instr_vld = instr_vld_q;

    // Redirect outranks stall; a pending skid word drains before new data.
    always_comb begin
        if (redir) begin
            mode = StRedir;
        end else if (stall_flg) begin
            mode = StHold;
        end else if (skid_vld_q) begin
            mode = StDrain;
        end else begin
            mode = StRun;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        req_vld_d   = req_vld_q;
        req_pc_d    = req_pc_q;
        skid_d      = skid_q;
        skid_pc_d   = skid_pc_q;
        skid_vld_d  = skid_vld_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        instr_vld_d = instr_vld_q;

        unique case (mode)
            StRedir: begin
                // Flush everything in flight; instr/instr_pc keep stale values.
                pc_d        = tgt_addr;
                req_vld_d   = 1'b0;
                skid_vld_d  = 1'b0;
                instr_vld_d = 1'b0;
            end
            StHold: begin
                req_vld_d = 1'b0;
                // Only the first stalled cycle can see a returning word.
                if (req_vld_q && !skid_vld_q) begin
                    skid_d     = imem_data;
                    skid_pc_d  = req_pc_q;
                    skid_vld_d = 1'b1;
                end
            end
            StDrain: begin
                pc_d        = pc_q + ADDR_W'(1);
                req_vld_d   = 1'b1;
                req_pc_d    = pc_q;
                instr_d     = skid_q;
                instr_pc_d  = skid_pc_q;
                instr_vld_d = 1'b1;
                skid_vld_d  = 1'b0;
            end
            StRun: begin
                pc_d        = pc_q + ADDR_W'(1);
                req_vld_d   = 1'b1;
                req_pc_d    = pc_q;
                instr_vld_d = req_vld_q;
                // Bubble slots keep the previous word for determinism.
                if (req_vld_q) begin
                    instr_d    = imem_data;
                    instr_pc_d = req_pc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_vld_q   <= 1'b0;
            req_pc_q    <= '0;
            skid_q      <= '0;
            skid_pc_q   <= '0;
            skid_vld_q  <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            instr_vld_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_vld_q   <= req_vld_d;
            req_pc_q    <= req_pc_d;
            skid_q      <= skid_d;
            skid_pc_q   <= skid_pc_d;
            skid_vld_q  <= skid_vld_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            instr_vld_q <= instr_vld_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the NanoQuarter pipeline. It owns the program counter, drives the synchronous instruction memory, and registers fetched 16-bit words into the IF/ID register. The control stage decodes these words into opcode/funct. The control stage's `stall_flg` and jump/branch decisions come back to this block to hold or redirect fetch. A one-entry skid buffer ensures that no word in flight is lost when a stall is raised.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction address width. Addresses are word-addressed, one 16-bit word per address.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_flg` in 1: hold fetch and the IF/ID register.
- `jmp_flg` in 1: unconditional redirect.
- `brnch_flg` in 1: branch instruction resolved this cycle.
- `brnch_taken` in 1: branch condition is true. Only meaningful when `brnch_flg`=1.
- `tgt_addr` in ADDR_W: redirect target.
- `imem_addr` out ADDR_W: instruction memory read address. Combinational, equal to `pc_q`.
- `imem_rd` out 1: read enable. The memory returns `imem_data` one cycle after an enabled read.
- `imem_data` in 16: read data.
- `instr` out 16: IF/ID instruction register.
- `instr_pc` out ADDR_W: address of `instr`.
- `instr_vld` out 1: `instr` holds a real instruction. When 0, downstream treats the slot as a nop.

## Operation

- Redirect condition: `redir` = `jmp_flg` | (`brnch_flg` & `brnch_taken`). A redirect has priority over `stall_flg`.
- Internal state:
  - `pc_q`: next address to request.
  - `req_vld_q` and `req_pc_q`: whether a read was issued last cycle, and its address.
  - `skid_q`, `skid_pc_q`, `skid_vld_q`: one-entry skid buffer.
- States:
  - RUN: `skid_vld_q`=0 and not stalled.
  - HOLD: `stall_flg`=1.
  - DRAIN: first non-stalled cycle with `skid_vld_q`=1.
- `imem_rd` = ~`stall_flg` & ~`redir`.
- Each edge, evaluated in priority order:
  - **redir:** `pc_q`<=`tgt_addr`; `req_vld_q`<=0; `skid_vld_q`<=0; `instr_vld`<=0. `instr` and `instr_pc` are don't-care.
  - **stall:** `pc_q`, `instr`, `instr_pc` and `instr_vld` hold, and `req_vld_q`<=0. If `req_vld_q`=1 and `skid_vld_q`=0, then `skid_q`<=`imem_data`, `skid_pc_q`<=`req_pc_q` and `skid_vld_q`<=1.
  - **normal:** `pc_q`<=`pc_q`+1, wrapping 2^ADDR_W-1 to 0 (mod-2^ADDR_W, no overflow flag). `req_vld_q`<=1 and `req_pc_q`<=`pc_q`. The IF/ID register then loads as follows:
    - If `skid_vld_q`=1: `instr`<=`skid_q`, `instr_pc`<=`skid_pc_q`, `instr_vld`<=1, `skid_vld_q`<=0 (DRAIN).
    - Otherwise: `instr`<=`imem_data`, `instr_pc`<=`req_pc_q`, `instr_vld`<=`req_vld_q`.
- DRAIN never collides with a returning word: `req_vld_q` is always 0 on the first cycle after HOLD.
- Outputs that are don't-care must still be deterministic. `instr` and `instr_pc` keep their previous value.

## Timing

- Reset (asynchronous assert, any cycle, including mid-stall or mid-redirect):
  - `pc_q`=RESET_PC.
  - `req_vld_q`=0 and `skid_vld_q`=0.
  - `instr`=16'h0000, `instr_pc`=0, `instr_vld`=0.
  - `imem_addr`=RESET_PC; `imem_rd` follows its equation.
- Fetch latency: address A is issued in cycle N, and `instr`=mem[A] with `instr_vld`=1 in cycle N+2. At steady state this gives one valid instruction per cycle.
- Redirect in cycle N:
  - `instr_vld`=0 in cycle N+1.
  - The target is issued in N+1, and mem[tgt] appears in N+3.
  - Bubbles inserted: 2.
- Stall held for cycles N..N+k-1: `instr`/`instr_vld` are frozen through N+k.
- Stall released at edge N+k: the skid word (if any) appears in N+k+1, followed by mem[`pc_q`] in N+k+2. No duplicate instruction and no lost instruction.
- `stall_flg` and `redir` in the same cycle: redirect wins, and the skid is flushed.
- A stall that is 1 cycle long behaves identically to a longer one.
- Redirect to the current `pc_q`: legal, and costs 2 bubbles.

## Test plan

- **Reset and stream:** RESET_PC=0, mem[i]=16'hA000+i, no stall. Release reset → `instr_vld` rises in cycle 2 with `instr`=A000, `instr_pc`=0. Then A001, A002, … on consecutive cycles.
- **Stall with skid:** stall asserted for 3 cycles while A005 is in flight → `instr` frozen at A004. Then A005 (from the skid), then A006. No gap, no duplicate; `imem_rd`=0 during the stall.
- **Jump:** `jmp_flg` with `tgt_addr`=8'h40 while streaming → next `instr_vld`=0 for 2 cycles, then `instr`=mem[40], `instr_pc`=40.
- **Branch not taken vs taken:**
  - `brnch_flg`=1, `brnch_taken`=0 → stream uninterrupted.
  - `brnch_flg`=1, `brnch_taken`=1, target 8'h10 → 2 bubbles, then mem[10].
- **Simultaneous stall and jump with a full skid:** stall 2 cycles, then stall+`jmp_flg` to 8'h20 → skid discarded, `instr_vld`=0. The next valid instruction is mem[20], 2 cycles later.
- **Wrap and async reset:**
  - ADDR_W=8, jump to 8'hFE → `instr_pc` sequence FE, FF, 00.
  - Assert `rst` mid-stream between clock edges → all outputs reach their reset values immediately, and fetch restarts at RESET_PC.
